mem_row_fetch: RTL and testbench
================================

// Module: mem_row_fetch
// PURPOSE
//  Read-side sequencer for the 256 x 256-bit matrix storage memory. On a start
//  command it issues consecutive row reads from a base address, absorbs the
//  1-cycle registered read latency in a small FIFO, and streams rows downstream
//  to the compute datapath over valid/ready. It never writes the memory.
// PARAMETERS
//  DATA_W      256  row width in bits; equals memory word width
//  ADDR_W      8    memory address width; 2**ADDR_W rows
//  FIFO_DEPTH  2    row buffer entries; power of two, >= 2
// PORTS
//  clk_i        in   1          clock; all state updates on posedge
//  rst_i        in   1          synchronous, active-high reset
//  start_i      in   1          1-cycle command strobe; ignored while busy_o=1
//  base_addr_i  in   ADDR_W     first row address; sampled with start_i
//  num_rows_i   in   ADDR_W+1   rows to fetch, 0..256; sampled with start_i
//  busy_o       out  1          command accepted and not yet complete
//  done_o       out  1          1-cycle pulse when a command completes
//  mem_en_o     out  1          memory enable; 1 only in read-issue cycles
//  mem_rw_o     out  1          memory read/write select; 1 whenever mem_en_o=1
//  mem_addr_o   out  ADDR_W     memory row address
//  mem_data_i   in   DATA_W     memory read data; undefined/Z unless returning
//  row_data_o   out  DATA_W     row to downstream (FIFO head)
//  row_valid_o  out  1          row_data_o valid
//  row_ready_i  in   1          downstream accepts; transfer = valid & ready
//  row_last_o   out  1          qualifies the final row of the command
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, counters 0; busy_o, done_o, mem_en_o,
//   row_valid_o, row_last_o = 0; mem_rw_o = 1; mem_addr_o, row_data_o = 0.
//  FSM IDLE -> FETCH on start_i with num_rows_i != 0; issue_cnt = num_rows_i,
//   addr = base_addr_i, busy_o = 1 from the next cycle.
//  start_i with num_rows_i = 0: no reads, done_o pulses the next cycle, stays IDLE.
//  FETCH: read issued in a cycle when issue_cnt != 0 and
//   (fifo_count + inflight) < FIFO_DEPTH; in that cycle mem_en_o = 1,
//   mem_addr_o = addr. Then addr += 1 mod 2**ADDR_W (255 wraps to 0), issue_cnt -= 1.
//  Read latency: data issued in cycle N is on mem_data_i in cycle N+1 and is
//   written to the FIFO at the end of N+1; inflight is a 1-bit flag.
//  mem_data_i is ignored in every cycle not flagged by inflight.
//  FETCH -> DRAIN when the last read is issued. DRAIN -> IDLE on the transfer
//   of the last row; done_o pulses the cycle after that transfer, busy_o drops
//   in the same cycle.
//  First-row latency with ready held high: start in cycle 0, issue cycle 1,
//   data cycle 2, row_valid_o cycle 3. Steady state: 1 row/cycle.
//  Backpressure: row_data_o and row_last_o hold stable while valid & !ready.
//   The credit check keeps the FIFO from overflowing and drops no row.
//  FIFO push and pop may occur in the same cycle; count is unchanged.
//  A pop from a full FIFO frees one issue slot in the next cycle, not the same one.
//  row_last_o = 1 only with row_valid_o on the command's final row.
//  Reset mid-command: FIFO, in-flight read and counters are discarded at once.
//   No done_o pulse is generated for the aborted command.
// STRUCTURE
//  matrix_pkg: DATA_W/ADDR_W constants, fetch_state_t enum {IDLE,FETCH,DRAIN}.
//  Sub-module row_fifo: synchronous FIFO, DATA_W+1 bits wide (data + last),
//   FIFO_DEPTH entries, same clk_i/rst_i, push/pop/count/full/empty.
//  Top holds the FSM, address/issue counters, inflight flag and credit logic.
// TESTING
//  Preload mem[i]=i; start base=0x10 n=4, ready=1 -> rows 0x10..0x13 in cycles 3..6, last on 0x13, done cycle 7.
//  base=0xFE n=4 -> mem_addr_o sequence FE,FF,00,01; row data in the same order.
//  n=8, ready low for cycles 3..10 -> at most 2 reads outstanding, 8 rows in order, none lost or repeated.
//  n=0 -> mem_en_o never 1, done_o pulse the next cycle, busy_o stays 0.
//  start_i re-asserted while busy_o=1 -> ignored; only the original row count is delivered.
//  rst_i in the middle of n=16 -> next cycle all outputs are at reset values; a new n=2 command runs cleanly.
//  Random ready, n=256 -> all 256 rows in order; addr wraps, busy_o=1 for the whole command.

Source files
------------

// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
//   Shared constants and types for the matrix storage read path.
//   - MAT_DATA_W     : width of one matrix row / memory word
//   - MAT_ADDR_W     : memory address width (2**MAT_ADDR_W rows)
//   - MAT_FIFO_DEPTH : default row buffer depth in the read sequencer
//   - fetch_state_t  : read sequencer states
//   - fifo_cnt_w()   : width of an occupancy counter for a given depth
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int MAT_DATA_W     = 256;
  localparam int MAT_ADDR_W     = 8;
  localparam int MAT_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // An occupancy counter must be able to hold the value 'depth' itself.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/row_fifo.sv
// -----------------------------------------------------------------------------
// row_fifo
//   Small synchronous FIFO used to absorb the memory read latency between the
//   read sequencer and the downstream row consumer. Each entry carries one row
//   plus its 'last' qualifier.
// Ports
//   clk_i      in   clock
//   rst_i      in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_data at the tail
//   push_data  in   WIDTH-bit entry
//   pop        in   remove the head entry
//   pop_data   out  head entry (meaningful only when !empty)
//   count      out  number of stored entries, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
// -----------------------------------------------------------------------------
module row_fifo
  import matrix_pkg::*;
#(
  parameter int WIDTH = MAT_DATA_W + 1,
  parameter int DEPTH = MAT_FIFO_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same
  // cycle; a pop from an empty FIFO is dropped.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = store_q[rd_ptr_q];

  // Storage carries no reset: entries are only observed once counted.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      store_q[wr_ptr_q] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_row_fetch.sv
// -----------------------------------------------------------------------------
// mem_row_fetch
//   Read-side sequencer for the matrix storage memory. A start command issues
//   consecutive row reads from a base address, the registered 1-cycle read
//   data is caught in a small FIFO, and rows are streamed downstream over a
//   valid/ready handshake. The memory is never written.
// Ports
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   start_i      in   command strobe, ignored while busy_o
//   base_addr_i  in   first row address (sampled with start_i)
//   num_rows_i   in   rows to fetch, 0..2**ADDR_W (sampled with start_i)
//   busy_o       out  command accepted and not yet complete
//   done_o       out  1-cycle completion pulse
//   mem_en_o     out  memory enable, high only in read-issue cycles
//   mem_rw_o     out  memory read/write select, constantly read (1)
//   mem_addr_o   out  memory row address
//   mem_data_i   in   memory read data, valid the cycle after an issue
//   row_data_o   out  FIFO head row
//   row_valid_o  out  row_data_o valid
//   row_ready_i  in   downstream accepts
//   row_last_o   out  final row of the command
// -----------------------------------------------------------------------------
module mem_row_fetch
  import matrix_pkg::*;
#(
  parameter int DATA_W     = MAT_DATA_W,
  parameter int ADDR_W     = MAT_ADDR_W,
  parameter int FIFO_DEPTH = MAT_FIFO_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   num_rows_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_en_o,
  output logic              mem_rw_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] row_data_o,
  output logic              row_valid_o,
  input  logic              row_ready_i,
  output logic              row_last_o
);

  localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [ADDR_W:0] LAST_ROW = (ADDR_W+1)'(1);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   issue_cnt_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              busy_q;
  logic              done_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_head;
  logic              pop;
  logic              last_pop;
  logic [OCC_W-1:0]  occupancy;
  logic              credit_ok;
  logic              issue;

  assign pop      = row_valid_o && row_ready_i;
  assign last_pop = pop && fifo_head[DATA_W];

  // Credit: every buffered row and the read still in flight reserve one FIFO
  // slot. When exactly DEPTH slots are reserved, a pop in this cycle lets a
  // new read go out so the stream keeps one row per cycle. A pop from a full
  // FIFO does not count here; that slot is only reused a cycle later.
  always_comb begin
    occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q);
    credit_ok = 1'b0;
    if (occupancy < OCC_W'(FIFO_DEPTH)) begin
      credit_ok = 1'b1;
    end else if ((occupancy == OCC_W'(FIFO_DEPTH)) && pop && !fifo_full) begin
      credit_ok = 1'b1;
    end
    issue = (state_q == FETCH) && (issue_cnt_q != '0) && credit_ok;
  end

  assign mem_en_o   = issue;
  assign mem_rw_o   = 1'b1;
  assign mem_addr_o = addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

  // Read data is only captured in the cycle after an issue; the last flag
  // travels alongside it so the consumer sees it with the final row.
  row_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (inflight_q),
    .push_data ({inflight_last_q, mem_data_i}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Outputs are forced to zero while the FIFO is empty so stale entries and
  // uninitialised storage never show on the row interface.
  assign row_valid_o = !fifo_empty;
  assign row_data_o  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign row_last_o  = !fifo_empty && fifo_head[DATA_W];

  // Sequencer: command acceptance, address / issue counting, completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && (issue_cnt_q == LAST_ROW);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (num_rows_i != '0) begin
              state_q     <= FETCH;
              addr_q      <= base_addr_i;
              issue_cnt_q <= num_rows_i;
              busy_q      <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (issue) begin
            addr_q      <= addr_q + 1'b1;
            issue_cnt_q <= issue_cnt_q - 1'b1;
            if (issue_cnt_q == LAST_ROW) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_row_fetch.sv
// -----------------------------------------------------------------------------
// tb_mem_row_fetch
//   Directed bench for mem_row_fetch. A behavioural memory returns a row
//   pattern derived from the address one cycle after each read issue and a
//   distinctive garbage word in every other cycle. Commands come from a table;
//   reset behaviour is covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mem_row_fetch;

  localparam int DATA_W     = 256;
  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 2;
  localparam logic [DATA_W-1:0] GARBAGE = {8{32'hDEAD_BEEF}};

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_rows;
  logic              busy;
  logic              done;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] row_data;
  logic              row_valid;
  logic              row_ready;
  logic              row_last;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   num;
    int                mode;       // 0 ready high, 1 random ready, 2 ready low window
    int                lo_from;
    int                lo_to;
    int                restart_a;  // cycles where start is re-asserted (-1 none)
    int                restart_b;
    int                exp_done;   // expected done cycle, -1 = not timed
    int                budget;
  } cmd_vec_t;

  cmd_vec_t vecs [7];

  mem_row_fetch #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .num_rows_i  (num_rows),
    .busy_o      (busy),
    .done_o      (done),
    .mem_en_o    (mem_en),
    .mem_rw_o    (mem_rw),
    .mem_addr_o  (mem_addr),
    .mem_data_i  (mem_data),
    .row_data_o  (row_data),
    .row_valid_o (row_valid),
    .row_ready_i (row_ready),
    .row_last_o  (row_last)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rowPattern(input logic [ADDR_W-1:0] a);
    return {32{a}};
  endfunction

  // Registered-read memory model.
  always @(posedge clk) begin
    if (mem_en && mem_rw) mem_data <= rowPattern(mem_addr);
    else                  mem_data <= GARBAGE;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [ADDR_W-1:0] b,
                               input logic [ADDR_W:0] n, input logic r);
    start     = s;
    base_addr = b;
    num_rows  = n;
    row_ready = r;
  endtask

  function automatic logic readyFor(input cmd_vec_t v, input int cyc);
    if (v.mode == 1) return 1'($urandom_range(0, 1));
    if (v.mode == 2) return !(cyc >= v.lo_from && cyc <= v.lo_to);
    return 1'b1;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " busy"},      DATA_W'(busy),      '0);
    checkOutput({tag, " done"},      DATA_W'(done),      '0);
    checkOutput({tag, " mem_en"},    DATA_W'(mem_en),    '0);
    checkOutput({tag, " mem_rw"},    DATA_W'(mem_rw),    DATA_W'(1));
    checkOutput({tag, " mem_addr"},  DATA_W'(mem_addr),  '0);
    checkOutput({tag, " row_valid"}, DATA_W'(row_valid), '0);
    checkOutput({tag, " row_last"},  DATA_W'(row_last),  '0);
    checkOutput({tag, " row_data"},  row_data,           '0);
  endtask

  // Runs one command; cycle 0 is the cycle in which start is driven.
  task automatic runCommand(input cmd_vec_t v, input int idx);
    int issued = 0, received = 0, done_cyc = -1;
    int busy_errs = 0, addr_errs = 0, out_errs = 0, lastq_errs = 0;
    int hold_errs = 0, timing_errs = 0;
    logic s, r, hold_pending = 1'b0, held_last = 1'b0;
    logic [DATA_W-1:0] held_data = '0;
    string tag = $sformatf("v%0d", idx);

    @(posedge clk); #1;
    applyStimulus(1'b1, v.base, v.num, readyFor(v, 0));
    @(negedge clk);
    if (busy !== 1'b0) busy_errs++;

    for (int cyc = 1; cyc <= v.budget && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      s = (cyc == v.restart_a) || (cyc == v.restart_b);
      r = readyFor(v, cyc);
      applyStimulus(s, s ? (v.base ^ 8'h80) : 8'hA5, s ? 9'd5 : 9'h1FF, r);
      @(negedge clk);
      if (hold_pending && (!row_valid || row_data !== held_data || row_last !== held_last))
        hold_errs++;
      if (mem_en) begin
        if (mem_addr !== ADDR_W'(v.base + issued[7:0])) addr_errs++;
        if (mem_rw !== 1'b1) addr_errs++;
        issued++;
      end
      if (row_valid && row_ready) begin
        checkOutput($sformatf("%s row%0d data", tag, received), row_data,
                    rowPattern(ADDR_W'(v.base + received[7:0])));
        checkOutput($sformatf("%s row%0d last", tag, received), DATA_W'(row_last),
                    DATA_W'(received == int'(v.num) - 1));
        if (v.mode == 0 && v.exp_done >= 0 && cyc != 3 + received) timing_errs++;
        received++;
      end
      if (row_last && !row_valid) lastq_errs++;
      if (issued - received > FIFO_DEPTH) out_errs++;
      hold_pending = row_valid && !row_ready;
      held_data    = row_data;
      held_last    = row_last;
      if (done) begin
        done_cyc = cyc;
        if (busy !== 1'b0) busy_errs++;
      end else if (busy !== (v.num != '0)) begin
        busy_errs++;
      end
    end

    if (done_cyc < 0) begin
      checkOutput({tag, " done timeout"}, '0, DATA_W'(1));
    end else if (v.exp_done >= 0) begin
      checkOutput({tag, " done cycle"}, DATA_W'(done_cyc), DATA_W'(v.exp_done));
    end
    checkOutput({tag, " rows delivered"}, DATA_W'(received), DATA_W'(v.num));
    checkOutput({tag, " reads issued"},   DATA_W'(issued),   DATA_W'(v.num));
    checkOutput({tag, " busy errors"},    DATA_W'(busy_errs),   '0);
    checkOutput({tag, " addr errors"},    DATA_W'(addr_errs),   '0);
    checkOutput({tag, " outstanding"},    DATA_W'(out_errs),    '0);
    checkOutput({tag, " last w/o valid"}, DATA_W'(lastq_errs),  '0);
    checkOutput({tag, " backpressure hold"}, DATA_W'(hold_errs), '0);
    checkOutput({tag, " row timing"},     DATA_W'(timing_errs), '0);

    @(posedge clk); #1;
    applyStimulus(1'b0, 8'h00, 9'd0, 1'b1);
    @(negedge clk);
    checkOutput({tag, " done one-shot"}, DATA_W'(done), '0);
    checkOutput({tag, " idle busy"},     DATA_W'(busy), '0);
  endtask

  initial begin
    int stray;

    vecs[0] = '{base:8'h10, num:9'd4,   mode:0, lo_from:0, lo_to:0,  restart_a:-1, restart_b:-1, exp_done:7,  budget:40};
    vecs[1] = '{base:8'hFE, num:9'd4,   mode:0, lo_from:0, lo_to:0,  restart_a:-1, restart_b:-1, exp_done:7,  budget:40};
    vecs[2] = '{base:8'h20, num:9'd8,   mode:2, lo_from:3, lo_to:10, restart_a:-1, restart_b:-1, exp_done:20, budget:60};
    vecs[3] = '{base:8'h33, num:9'd0,   mode:0, lo_from:0, lo_to:0,  restart_a:-1, restart_b:-1, exp_done:1,  budget:20};
    vecs[4] = '{base:8'h40, num:9'd3,   mode:0, lo_from:0, lo_to:0,  restart_a:2,  restart_b:4,  exp_done:6,  budget:40};
    vecs[5] = '{base:8'hF0, num:9'd256, mode:1, lo_from:0, lo_to:0,  restart_a:-1, restart_b:-1, exp_done:-1, budget:3000};
    vecs[6] = '{base:8'h7F, num:9'd1,   mode:0, lo_from:0, lo_to:0,  restart_a:-1, restart_b:-1, exp_done:4,  budget:20};

    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 9'd0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("por");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      runCommand(vecs[i], i);
    end

    // Reset in the middle of a 16-row command.
    @(posedge clk); #1;
    applyStimulus(1'b1, 8'h30, 9'd16, 1'b1);
    repeat (6) begin
      @(posedge clk); #1;
      applyStimulus(1'b0, 8'hA5, 9'h1FF, 1'b1);
    end
    @(negedge clk);
    checkOutput("mid busy before reset", DATA_W'(busy), DATA_W'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("mid");
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || mem_en || row_valid || busy) stray++;
    end
    checkOutput("mid no activity after reset", DATA_W'(stray), '0);
    runCommand('{base:8'h55, num:9'd2, mode:0, lo_from:0, lo_to:0, restart_a:-1,
                 restart_b:-1, exp_done:5, budget:30}, 7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
